imem_bus_responder: RTL and testbench
=====================================

Name: imem_bus_responder

Overview:
- Parametrised memory-side responder for the core's valid/ready memory bus, used in formal and simulation benches around the riscv core.
- Generates configurable wait states and returns read data.
- Overrides the read data with NWATCH tracked instruction halfwords, so fetches are consistent with checker-chosen words; stores keep those halfwords coherent.
- Flags core-side protocol violations (request dropped or changed while pending).

Parameters:
- NWATCH, 2, number of tracked halfword entries (1..8).
- MAX_WAIT, 4, maximum wait cycles before mem_ready (0..15).
- WAIT_MODE, 1, 0 = zero-wait; 1 = fixed MAX_WAIT; 2 = pseudo-random 0..MAX_WAIT from a 16-bit LFSR.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be non-zero.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous, active-low reset.
- mem_valid  in  1  core request valid.
- mem_instr  in  1  request is an instruction fetch.
- mem_addr  in  32  request byte address, word aligned.
- mem_wdata  in  32  store data.
- mem_wstrb  in  4  byte write strobes; 0 = read.
- mem_ready  out  1  one-cycle completion pulse.
- mem_rdata  out  32  read data, valid when mem_ready=1.
- bg_rdata  in  32  background data for non-tracked bytes (free input in formal).
- load_en  in  1  load one tracked entry.
- load_idx  in  3  entry index, taken modulo NWATCH.
- load_addr  in  32  halfword address to track, bit0 ignored.
- load_data  in  16  initial halfword contents.
- watch_hit  out  1  registered; the last completed fetch returned at least one tracked halfword.
- err_protocol  out  1  sticky protocol violation flag.
- stall_count  out  16  saturating count of wait cycles since reset.

Behaviour:
- Reset (resetn=0 at posedge):
  - FSM=IDLE; mem_ready=0, mem_rdata=0, watch_hit=0, err_protocol=0, stall_count=0.
  - LFSR=LFSR_SEED; all entries invalid.
  - Reset mid-request abandons the request; no mem_ready is issued for it.
- FSM:
  - IDLE: when mem_valid=1, latch addr/instr/wdata/wstrb and the wait target W.
    - W = 0 in mode 0; W = MAX_WAIT in mode 1; W = LFSR mod (MAX_WAIT+1) in mode 2.
    - The LFSR advances once per accepted request.
    - If W=0, go to RESP; otherwise go to WAIT with counter=1.
  - WAIT: increment stall_count (saturates at 16'hFFFF). When counter==W go to RESP; otherwise counter+1.
  - RESP: mem_ready=1 for exactly this cycle, with mem_rdata driven; go to IDLE.
  - Latency is W+1 cycles from the mem_valid sample to mem_ready. Back-to-back requests are allowed: IDLE can accept in the cycle after RESP.
- Read data (computed at RESP from the latched request):
  - Base value is bg_rdata.
  - Tracked entry e is valid with e.addr[31:1] == {req_addr[31:2],0} → bits [15:0] = e.data.
  - Tracked entry e is valid with e.addr[31:1] == {req_addr[31:2],1} → bits [31:16] = e.data.
  - If several entries match the same halfword, the lowest index wins.
  - Overrides apply to both fetches and data loads.
  - watch_hit is updated at RESP: 1 iff mem_instr=1 and at least one override applied. It holds until the next RESP.
- Stores (wstrb≠0) at RESP: for each matching entry, each halfword byte whose strobe is set is replaced from wdata. Partial strobes update only the strobed byte. mem_rdata=0 for stores.
- Loading:
  - load_en in any state writes the entry and sets it valid; the write is visible to a RESP in the next cycle or later.
  - If load_en and a store update hit the same entry in the same cycle, load wins.
- Protocol check, while in WAIT, and in RESP before the pulse: err_protocol is set (sticky until reset) on any of the following:
  - mem_valid=0;
  - mem_addr, mem_wstrb or mem_instr differing from the latched value;
  - mem_wdata changing during a store.
- mem_valid=1 in the cycle after RESP is treated as a new request, not a violation.
- Addresses wrap modulo 2^32; there is no special case at 32'hFFFFFFFC.

Test Plan:
- WAIT_MODE=0, NWATCH=2: load entry0 = (0x100, 0xBEEF), entry1 = (0x102, 0x1234); fetch 0x100 → mem_ready 1 cycle after valid, mem_rdata=0x1234BEEF, watch_hit=1.
- WAIT_MODE=1, MAX_WAIT=3: any read → mem_ready on the 4th cycle after valid; stall_count=3 after one request, 6 after two back-to-back requests.
- Store to 0x100, wdata=0xAABBCCDD, wstrb=4'b0010, then fetch 0x100 → low halfword 0xCCEF, high halfword from bg_rdata if no entry tracks 0x102.
- Core drops mem_valid during WAIT (MAX_WAIT=2) → err_protocol=1 from the next cycle, still 1 after 10 idle cycles, cleared only by resetn=0.
- resetn=0 asserted in WAIT → no mem_ready, all outputs 0, entries invalid; a fetch of 0x100 afterwards returns bg_rdata, watch_hit=0.
- WAIT_MODE=2, MAX_WAIT=4, 200 requests → every latency is in 1..5, err_protocol stays 0, and every wait value 0..4 occurs at least once.

Source files
------------

// File: rtl/imem_bus_responder.sv
`default_nettype none
// ============================================================================
// imem_bus_responder: valid/ready memory responder with wait states and
// tracked-halfword read overrides kept coherent by stores. Rev 1.0
// ============================================================================
module imem_bus_responder #(
  parameter int          NWATCH    = 2,
  parameter int          MAX_WAIT  = 4,
  parameter int          WAIT_MODE = 1,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  input  logic [31:0] bg_rdata,
  input  logic        load_en,
  input  logic [2:0]  load_idx,
  input  logic [31:0] load_addr,
  input  logic [15:0] load_data,
  output logic        watch_hit,
  output logic        err_protocol,
  output logic [15:0] stall_count
);

  localparam logic [15:0] WAIT_MOD = 16'(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        req_instr;
  logic [3:0]  wait_tgt, cnt, wait_sel, load_sel;
  logic [15:0] lfsr, lfsr_nxt;

  logic [NWATCH-1:0] ent_valid, lo_match, hi_match;
  logic [30:0]       ent_addr [NWATCH];
  logic [15:0]       ent_data [NWATCH];

  logic [31:0] rd_merge;
  logic        lo_hit, hi_hit, viol, is_store, unused_bits;

  assign unused_bits = load_addr[0];
  assign is_store    = (req_wstrb != 4'd0);
  assign lfsr_nxt    = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign load_sel    = 4'({1'b0, load_idx} % 4'(NWATCH));

  always_comb begin
    wait_sel = 4'd0;
    if (WAIT_MODE == 1)      wait_sel = 4'(MAX_WAIT);
    else if (WAIT_MODE == 2) wait_sel = 4'(lfsr % WAIT_MOD);
  end

  always_ff @(posedge clk) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (mem_valid) state_nxt = (wait_sel == 4'd0) ? S_RESP : S_WAIT;
      S_WAIT:  if (cnt == wait_tgt) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // The core must hold the request unchanged until it has seen mem_ready.
  assign viol = ((state == S_WAIT) || (state == S_RESP)) &&
                (!mem_valid || (mem_addr != req_addr) || (mem_wstrb != req_wstrb) ||
                 (mem_instr != req_instr) || (is_store && (mem_wdata != req_wdata)));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      req_addr     <= '0;
      req_wdata    <= '0;
      req_wstrb    <= '0;
      req_instr    <= 1'b0;
      wait_tgt     <= '0;
      cnt          <= '0;
      lfsr         <= LFSR_SEED;
      stall_count  <= '0;
      err_protocol <= 1'b0;
      watch_hit    <= 1'b0;
    end else begin
      if (viol) err_protocol <= 1'b1;
      case (state)
        S_IDLE: if (mem_valid) begin
          req_addr  <= mem_addr;
          req_wdata <= mem_wdata;
          req_wstrb <= mem_wstrb;
          req_instr <= mem_instr;
          wait_tgt  <= wait_sel;
          cnt       <= 4'd1;
          lfsr      <= lfsr_nxt;
        end
        S_WAIT: begin
          cnt <= cnt + 4'd1;
          if (stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
        end
        S_RESP:  watch_hit <= req_instr && !is_store && (lo_hit || hi_hit);
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < NWATCH; g++) begin : g_match
    assign lo_match[g] = ent_valid[g] && (ent_addr[g] == {req_addr[31:2], 1'b0});
    assign hi_match[g] = ent_valid[g] && (ent_addr[g] == {req_addr[31:2], 1'b1});
  end

  // A load to an entry takes priority over a store hitting it in the same cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ent_valid <= '0;
    end else begin
      for (int i = 0; i < NWATCH; i++) begin
        if (load_en && (load_sel == 4'(i))) begin
          ent_valid[i] <= 1'b1;
          ent_addr[i]  <= load_addr[31:1];
          ent_data[i]  <= load_data;
        end else if ((state == S_RESP) && is_store) begin
          if (lo_match[i]) begin
            if (req_wstrb[0]) ent_data[i][7:0]  <= req_wdata[7:0];
            if (req_wstrb[1]) ent_data[i][15:8] <= req_wdata[15:8];
          end
          if (hi_match[i]) begin
            if (req_wstrb[2]) ent_data[i][7:0]  <= req_wdata[23:16];
            if (req_wstrb[3]) ent_data[i][15:8] <= req_wdata[31:24];
          end
        end
      end
    end
  end

  // Walk from the top so the lowest matching index is applied last and wins.
  always_comb begin
    rd_merge = bg_rdata;
    lo_hit   = 1'b0;
    hi_hit   = 1'b0;
    for (int i = NWATCH - 1; i >= 0; i--) begin
      if (lo_match[i]) begin
        rd_merge[15:0] = ent_data[i];
        lo_hit         = 1'b1;
      end
      if (hi_match[i]) begin
        rd_merge[31:16] = ent_data[i];
        hi_hit          = 1'b1;
      end
    end
  end

  assign mem_ready = (state == S_RESP);
  assign mem_rdata = ((state == S_RESP) && !is_store) ? rd_merge : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_imem_bus_responder.sv
`default_nettype none
// ============================================================================
// tb_imem_bus_responder: directed checks of three responder configurations
// (zero-wait, fixed wait, LFSR wait). Rev 1.0
// ============================================================================
module tb_imem_bus_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]        resetn, mem_valid, mem_instr, load_en, mem_ready, watch_hit, err_protocol;
  logic [2:0][31:0]  mem_addr, mem_wdata, bg_rdata, load_addr, mem_rdata;
  logic [2:0][3:0]   mem_wstrb;
  logic [2:0][2:0]   load_idx;
  logic [2:0][15:0]  load_data, stall_count;

  int n_checks = 0;
  int n_fail   = 0;

  imem_bus_responder #(.NWATCH(2), .MAX_WAIT(4), .WAIT_MODE(0)) u_dut0 (
    .clk(clk), .resetn(resetn[0]), .mem_valid(mem_valid[0]), .mem_instr(mem_instr[0]),
    .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_wstrb(mem_wstrb[0]),
    .mem_ready(mem_ready[0]), .mem_rdata(mem_rdata[0]), .bg_rdata(bg_rdata[0]),
    .load_en(load_en[0]), .load_idx(load_idx[0]), .load_addr(load_addr[0]),
    .load_data(load_data[0]), .watch_hit(watch_hit[0]), .err_protocol(err_protocol[0]),
    .stall_count(stall_count[0]));

  imem_bus_responder #(.NWATCH(2), .MAX_WAIT(3), .WAIT_MODE(1)) u_dut1 (
    .clk(clk), .resetn(resetn[1]), .mem_valid(mem_valid[1]), .mem_instr(mem_instr[1]),
    .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_wstrb(mem_wstrb[1]),
    .mem_ready(mem_ready[1]), .mem_rdata(mem_rdata[1]), .bg_rdata(bg_rdata[1]),
    .load_en(load_en[1]), .load_idx(load_idx[1]), .load_addr(load_addr[1]),
    .load_data(load_data[1]), .watch_hit(watch_hit[1]), .err_protocol(err_protocol[1]),
    .stall_count(stall_count[1]));

  imem_bus_responder #(.NWATCH(2), .MAX_WAIT(4), .WAIT_MODE(2), .LFSR_SEED(16'hACE1)) u_dut2 (
    .clk(clk), .resetn(resetn[2]), .mem_valid(mem_valid[2]), .mem_instr(mem_instr[2]),
    .mem_addr(mem_addr[2]), .mem_wdata(mem_wdata[2]), .mem_wstrb(mem_wstrb[2]),
    .mem_ready(mem_ready[2]), .mem_rdata(mem_rdata[2]), .bg_rdata(bg_rdata[2]),
    .load_en(load_en[2]), .load_idx(load_idx[2]), .load_addr(load_addr[2]),
    .load_data(load_data[2]), .watch_hit(watch_hit[2]), .err_protocol(err_protocol[2]),
    .stall_count(stall_count[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset(input int d);
    resetn[d] = 1'b0; mem_valid[d] = 1'b0; load_en[d] = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn[d] = 1'b1;
  endtask

  task automatic check_idle_outputs(input int d, input string tag);
    check({tag, "_ready"}, 32'(mem_ready[d]), 32'd0);
    check({tag, "_rdata"}, mem_rdata[d], 32'd0);
    check({tag, "_watch"}, 32'(watch_hit[d]), 32'd0);
    check({tag, "_err"}, 32'(err_protocol[d]), 32'd0);
    check({tag, "_stall"}, 32'(stall_count[d]), 32'd0);
  endtask

  task automatic load(input int d, input logic [2:0] idx, input logic [31:0] a, input logic [15:0] v);
    load_en[d] = 1'b1; load_idx[d] = idx; load_addr[d] = a; load_data[d] = v;
    @(posedge clk);
    #1 load_en[d] = 1'b0;
  endtask

  // Waits (bounded) for mem_ready, then holds the request through the pulse edge.
  task automatic finish_req(input int d, output int lat, output logic [31:0] rd);
    lat = 0;
    rd  = '0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (mem_ready[d]) begin
        lat = c;
        rd  = mem_rdata[d];
        break;
      end
    end
    if (lat == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL req_timeout: dut %0d gave no mem_ready within 20 cycles", d);
    end
    @(posedge clk);
    #1 mem_valid[d] = 1'b0;
  endtask

  task automatic req(input int d, input logic [31:0] a, input logic ins, input logic [31:0] wd,
                     input logic [3:0] ws, output int lat, output logic [31:0] rd);
    mem_valid[d] = 1'b1; mem_instr[d] = ins; mem_addr[d] = a; mem_wdata[d] = wd; mem_wstrb[d] = ws;
    finish_req(d, lat, rd);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int          lat, bad, stall_sum, quiet_ready;
    logic [31:0] rd;
    logic [4:0]  seen;

    resetn = '0; mem_valid = '0; mem_instr = '0; load_en = '0;
    mem_addr = '0; mem_wdata = '0; mem_wstrb = '0; load_idx = '0; load_addr = '0; load_data = '0;
    bg_rdata[0] = 32'h5566_7788;
    bg_rdata[1] = 32'hCAFE_0000;
    bg_rdata[2] = 32'h0BAD_F00D;

    // ---------------- zero-wait configuration ----------------
    do_reset(0);
    check_idle_outputs(0, "m0_reset");
    load(0, 3'd0, 32'h100, 16'hBEEF);
    load(0, 3'd1, 32'h102, 16'h1234);
    req(0, 32'h100, 1'b1, 32'h0, 4'h0, lat, rd);
    check("m0_fetch_lat", 32'(lat), 32'd1);
    check("m0_fetch_rdata", rd, 32'h1234_BEEF);
    check("m0_fetch_watch", 32'(watch_hit[0]), 32'd1);
    check("m0_ready_pulse", 32'(mem_ready[0]), 32'd0);
    req(0, 32'h104, 1'b1, 32'h0, 4'h0, lat, rd);
    check("m0_untracked_rdata", rd, 32'h5566_7788);
    check("m0_untracked_watch", 32'(watch_hit[0]), 32'd0);
    req(0, 32'h100, 1'b0, 32'h0, 4'h0, lat, rd);
    check("m0_dload_rdata", rd, 32'h1234_BEEF);
    check("m0_dload_watch", 32'(watch_hit[0]), 32'd0);
    req(0, 32'h100, 1'b0, 32'hAABB_CCDD, 4'b0010, lat, rd);
    check("m0_store_lat", 32'(lat), 32'd1);
    check("m0_store_rdata", rd, 32'd0);
    req(0, 32'h100, 1'b1, 32'h0, 4'h0, lat, rd);
    check("m0_after_store", rd, 32'h1234_CCEF);
    load(0, 3'd3, 32'h200, 16'h4242);
    req(0, 32'h100, 1'b1, 32'h0, 4'h0, lat, rd);
    check("m0_hi_from_bg", rd, 32'h5566_CCEF);
    check("m0_hi_from_bg_watch", 32'(watch_hit[0]), 32'd1);
    req(0, 32'h200, 1'b1, 32'h0, 4'h0, lat, rd);
    check("m0_idx_modulo", rd, 32'h5566_4242);
    load(0, 3'd1, 32'h100, 16'hFACE);
    req(0, 32'h100, 1'b1, 32'h0, 4'h0, lat, rd);
    check("m0_lowest_wins", rd, 32'h5566_CCEF);
    req(0, 32'h100, 1'b0, 32'h0000_1122, 4'b0011, lat, rd);
    req(0, 32'h100, 1'b1, 32'h0, 4'h0, lat, rd);
    check("m0_store_both", rd, 32'h5566_1122);
    load(0, 3'd0, 32'h301, 16'h7777);
    req(0, 32'h100, 1'b1, 32'h0, 4'h0, lat, rd);
    check("m0_entry1_stored", rd, 32'h5566_1122);
    req(0, 32'h300, 1'b1, 32'h0, 4'h0, lat, rd);
    check("m0_addr_bit0_ignored", rd, 32'h5566_7777);
    // store and load hit entry0 on the same edge
    mem_valid[0] = 1'b1; mem_instr[0] = 1'b0; mem_addr[0] = 32'h300;
    mem_wdata[0] = 32'h0000_ABCD; mem_wstrb[0] = 4'b0011;
    load_en[0] = 1'b1; load_idx[0] = 3'd0; load_addr[0] = 32'h300; load_data[0] = 16'h9999;
    @(posedge clk);
    #1 check("m0_ldwin_ready", 32'(mem_ready[0]), 32'd1);
    @(posedge clk);
    #1 begin mem_valid[0] = 1'b0; load_en[0] = 1'b0; end
    req(0, 32'h300, 1'b1, 32'h0, 4'h0, lat, rd);
    check("m0_load_wins", rd, 32'h5566_9999);
    load(0, 3'd1, 32'hFFFF_FFFE, 16'h5A5A);
    req(0, 32'hFFFF_FFFC, 1'b1, 32'h0, 4'h0, lat, rd);
    check("m0_top_addr", rd, 32'h5A5A_7788);
    check("m0_err_clean", 32'(err_protocol[0]), 32'd0);

    // ---------------- fixed-wait configuration ----------------
    do_reset(1);
    check_idle_outputs(1, "m1_reset");
    req(1, 32'h40, 1'b0, 32'h0, 4'h0, lat, rd);
    check("m1_lat_first", 32'(lat), 32'd4);
    check("m1_stall_one", 32'(stall_count[1]), 32'd3);
    req(1, 32'h44, 1'b0, 32'h0, 4'h0, lat, rd);
    check("m1_lat_b2b", 32'(lat), 32'd4);
    check("m1_stall_two", 32'(stall_count[1]), 32'd6);
    // wdata may change freely during a read
    mem_valid[1] = 1'b1; mem_instr[1] = 1'b0; mem_addr[1] = 32'h48; mem_wdata[1] = 32'h1; mem_wstrb[1] = 4'h0;
    @(posedge clk);
    #1 mem_wdata[1] = 32'hFFFF_0000;
    finish_req(1, lat, rd);
    check("m1_read_wdata_ok", 32'(err_protocol[1]), 32'd0);
    // drop mem_valid while waiting
    mem_valid[1] = 1'b1; mem_addr[1] = 32'h4C;
    @(posedge clk);
    @(posedge clk);
    #1 mem_valid[1] = 1'b0;
    @(posedge clk);
    #1 check("m1_drop_err", 32'(err_protocol[1]), 32'd1);
    repeat (10) @(posedge clk);
    #1 check("m1_drop_sticky", 32'(err_protocol[1]), 32'd1);
    do_reset(1);
    check("m1_err_cleared", 32'(err_protocol[1]), 32'd0);
    load(1, 3'd0, 32'h100, 16'hBEEF);
    req(1, 32'h100, 1'b1, 32'h0, 4'h0, lat, rd);
    check("m1_fetch_rdata", rd, 32'hCAFE_BEEF);
    check("m1_fetch_watch", 32'(watch_hit[1]), 32'd1);
    // change the address while pending
    mem_valid[1] = 1'b1; mem_instr[1] = 1'b1; mem_addr[1] = 32'h100; mem_wstrb[1] = 4'h0;
    @(posedge clk);
    #1 mem_addr[1] = 32'h104;
    @(posedge clk);
    #1 begin
      check("m1_addr_change_err", 32'(err_protocol[1]), 32'd1);
      mem_addr[1] = 32'h100;
    end
    finish_req(1, lat, rd);
    // reset in the middle of a waited fetch
    mem_valid[1] = 1'b1; mem_instr[1] = 1'b1; mem_addr[1] = 32'h100; mem_wstrb[1] = 4'h0;
    @(posedge clk);
    @(posedge clk);
    #1 begin resetn[1] = 1'b0; mem_valid[1] = 1'b0; end
    @(posedge clk);
    #1 begin
      check_idle_outputs(1, "m1_midreset");
      resetn[1] = 1'b1;
    end
    quiet_ready = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1 if (mem_ready[1]) quiet_ready++;
    end
    check("m1_no_ready_after_reset", 32'(quiet_ready), 32'd0);
    req(1, 32'h100, 1'b1, 32'h0, 4'h0, lat, rd);
    check("m1_entries_cleared", rd, 32'hCAFE_0000);
    check("m1_entries_cleared_watch", 32'(watch_hit[1]), 32'd0);

    // ---------------- LFSR-wait configuration ----------------
    do_reset(2);
    check_idle_outputs(2, "m2_reset");
    bad = 0; stall_sum = 0; seen = '0;
    for (int i = 0; i < 200; i++) begin
      req(2, 32'(i * 4), 1'b0, 32'h0, 4'h0, lat, rd);
      if (lat < 1 || lat > 5) bad++;
      else begin
        seen[lat - 1] = 1'b1;
        stall_sum += lat - 1;
      end
    end
    check("m2_lat_range", 32'(bad), 32'd0);
    for (int w = 0; w < 5; w++) check($sformatf("m2_seen_wait%0d", w), 32'(seen[w]), 32'd1);
    check("m2_stall_sum", 32'(stall_count[2]), 32'(stall_sum));
    check("m2_err_clean", 32'(err_protocol[2]), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
